// File: rtl/mdu_sched_if.sv
// Handshake/bus bundle between the EX/ID pipeline stages and the mult/div scheduler.
// master: pipeline side (drives op, operands, ID md flag); slave: scheduler side.
interface mdu_sched_if;
    logic [3:0]  e_md_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_is_md;
`ifdef MDU_CANCEL_EN
    logic        md_cancel;
`endif
    logic        busy;
    logic        start;
    logic        md_stall;
    logic [31:0] e_md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_md_op, e_rs, e_rt, d_is_md,
`ifdef MDU_CANCEL_EN
        output md_cancel,
`endif
        input  busy, start, md_stall, e_md_rdata, hi, lo
    );

    modport slave (
        input  e_md_op, e_rs, e_rt, d_is_md,
`ifdef MDU_CANCEL_EN
        input  md_cancel,
`endif
        output busy, start, md_stall, e_md_rdata, hi, lo
    );
endinterface

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide scheduler and HI/LO owner beside the EX stage.
// Ports: clk, reset (sync, active-high); bus (mdu_sched_if.slave):
//   in  e_md_op[3:0], e_rs[31:0], e_rt[31:0], d_is_md, md_cancel (MDU_CANCEL_EN only)
//   out busy, start, md_stall, e_md_rdata[31:0], hi[31:0], lo[31:0]
// Optional feature macro: MDU_CANCEL_EN (adds md_cancel abort of a running op).
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_sched_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_q;

    logic        cancel;
    logic        is_arith;
    logic        start;

`ifdef MDU_CANCEL_EN
    assign cancel = bus.md_cancel;
`else
    assign cancel = 1'b0;
`endif

    assign is_arith = (bus.e_md_op >= OP_MULT) && (bus.e_md_op <= OP_DIVU);
    // A cancel in the launch cycle suppresses the launch entirely.
    assign start    = is_arith & ~busy_q & ~cancel;

    assign bus.start    = start;
    assign bus.busy     = busy_q;
    assign bus.md_stall = bus.d_is_md & (start | busy_q);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    always_comb begin
        bus.e_md_rdata = 32'd0;
        if (bus.e_md_op == OP_MFHI) bus.e_md_rdata = hi_q;
        else if (bus.e_md_op == OP_MFLO) bus.e_md_rdata = lo_q;
    end

    // Results are formed from the latched operands only.
    logic [63:0] sa, sb, prod_s, prod_u;
    assign sa     = {{32{op_a[31]}}, op_a};
    assign sb     = {{32{op_b[31]}}, op_b};
    assign prod_s = sa * sb;
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000/-1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    logic [31:0] abs_a, abs_b, dvs_s, uq, ur, quo_s, rem_s;
    logic [31:0] dvs_u, quo_u, rem_u;
    logic        div_zero;
    assign div_zero = (op_b == 32'd0);
    assign abs_a    = op_a[31] ? -op_a : op_a;
    assign abs_b    = op_b[31] ? -op_b : op_b;
    // Divisor of zero is replaced by 1 only to keep the dividers defined;
    // the result is discarded in that case.
    assign dvs_s    = div_zero ? 32'd1 : abs_b;
    assign uq       = abs_a / dvs_s;
    assign ur       = abs_a % dvs_s;
    assign quo_s    = (op_a[31] ^ op_b[31]) ? -uq : uq;
    assign rem_s    = op_a[31] ? -ur : ur;
    assign dvs_u    = div_zero ? 32'd1 : op_b;
    assign quo_u    = op_a / dvs_u;
    assign rem_u    = op_a % dvs_u;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            op_q   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= bus.e_rs;
                        op_b   <= bus.e_rt;
                        op_q   <= bus.e_md_op;
                        cnt    <= (bus.e_md_op <= OP_MULTU) ?
                                  4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        state  <= BUSY;
                        busy_q <= 1'b1;
                    end else if (bus.e_md_op == OP_MTHI) begin
                        hi_q <= bus.e_rs;
                    end else if (bus.e_md_op == OP_MTLO) begin
                        lo_q <= bus.e_rs;
                    end
                end
                BUSY: begin
                    if (cancel) begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        busy_q <= 1'b0;
                    end else if (cnt == 4'd1) begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        busy_q <= 1'b0;
                        if (op_q == OP_MULT) begin
                            {hi_q, lo_q} <= prod_s;
                        end else if (op_q == OP_MULTU) begin
                            {hi_q, lo_q} <= prod_u;
                        end else if (op_q == OP_DIV && !div_zero) begin
                            hi_q <= rem_s;
                            lo_q <= quo_s;
                        end else if (op_q == OP_DIVU && !div_zero) begin
                            hi_q <= rem_u;
                            lo_q <= quo_u;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed vector table, hand-written
// multi-cycle sequences and randomized ops against a behavioural model.
module tb_mdu_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] mh, ml;

    always #5 clk = ~clk;

    mdu_sched_if bus ();

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules written directly from the instruction semantics.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        int sa, sb;
        longint ps;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (op)
            4'd1: begin ps = longint'(sa) * longint'(sb); {h, l} = ps; end
            4'd2: begin pu = {32'd0, a} * {32'd0, b}; {h, l} = pu; end
            4'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'd0;
                end else begin
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            4'd4: if (b != 0) begin l = a / b; h = a % b; end
            default: ;
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int cyc);
        int n;
        tick();
        bus.e_md_op = op;
        bus.e_rs = a;
        bus.e_rt = b;
        @(negedge clk);
        chk({nm, ".start"}, 32'(bus.start), 32'd1);
        tick();
        bus.e_md_op = 4'd0;
        bus.e_rs = $urandom;
        bus.e_rt = $urandom;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({nm, ".cycles"}, 32'(n), 32'(cyc));
        chk({nm, ".hi"}, bus.hi, ehi);
        chk({nm, ".lo"}, bus.lo, elo);
        bus.e_md_op = 4'd7;
        #1 chk({nm, ".mfhi"}, bus.e_md_rdata, ehi);
        bus.e_md_op = 4'd8;
        #1 chk({nm, ".mflo"}, bus.e_md_rdata, elo);
        bus.e_md_op = 4'd0;
    endtask

    vec_t vt[7];
    int   n;

    initial begin
        bus.e_md_op = 4'd0;
        bus.e_rs = 32'd0;
        bus.e_rt = 32'd0;
        bus.d_is_md = 1'b0;
`ifdef MDU_CANCEL_EN
        bus.md_cancel = 1'b0;
`endif
        vt[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vt[1] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vt[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vt[3] = '{4'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vt[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10};
        vt[5] = '{4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10};
        vt[6] = '{4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10};

        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.hi", bus.hi, 32'd0);
        chk("rst.lo", bus.lo, 32'd0);
        chk("rst.stall", 32'(bus.md_stall), 32'd0);
        chk("rst.start", 32'(bus.start), 32'd0);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].rs, vt[i].rt,
                   vt[i].ehi, vt[i].elo, vt[i].cyc);

        // MFLO held in ID across a MULT.
        tick();
        bus.e_md_op = 4'd1;
        bus.e_rs = 32'd3;
        bus.e_rt = 32'd5;
        bus.d_is_md = 1'b1;
        @(negedge clk);
        chk("stall.start", 32'(bus.md_stall), 32'd1);
        tick();
        bus.e_md_op = 4'd0;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 40) begin
            chk("stall.busy", 32'(bus.md_stall), 32'd1);
            n++;
            @(negedge clk);
        end
        chk("stall.cycles", 32'(n), 32'd5);
        chk("stall.after", 32'(bus.md_stall), 32'd0);
        bus.e_md_op = 4'd8;
        #1 chk("stall.mflo", bus.e_md_rdata, 32'd15);
        bus.d_is_md = 1'b0;

        // MTHI then MFHI.
        tick();
        bus.e_md_op = 4'd5;
        bus.e_rs = 32'h1234_5678;
        tick();
        bus.e_md_op = 4'd7;
        bus.e_rs = 32'd0;
        @(negedge clk);
        chk("mthi.hi", bus.hi, 32'h1234_5678);
        chk("mthi.rdata", bus.e_md_rdata, 32'h1234_5678);

        // MTLO and a second start while busy are both ignored.
        tick();
        bus.e_md_op = 4'd1;
        bus.e_rs = 32'd2;
        bus.e_rt = 32'd3;
        tick();
        bus.e_md_op = 4'd6;
        bus.e_rs = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mtlo_busy.lo", bus.lo, 32'd15);
        tick();
        bus.e_md_op = 4'd3;
        bus.e_rs = 32'd100;
        bus.e_rt = 32'd7;
        @(negedge clk);
        chk("start_busy.start", 32'(bus.start), 32'd0);
        tick();
        bus.e_md_op = 4'd0;
        n = 2;
        @(negedge clk);
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("start_busy.cycles", 32'(n), 32'd5);
        chk("start_busy.hi", bus.hi, 32'd0);
        chk("start_busy.lo", bus.lo, 32'd6);

        // Randomized ops against the model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mh = 32'd0;
        ml = 32'd0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 8));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            if (op >= 4'd1 && op <= 4'd4) begin
                model(op, a, b, mh, ml);
                run_op($sformatf("rnd%0d", i), op, a, b, mh, ml,
                       (op <= 4'd2) ? 5 : 10);
            end else if (op == 4'd5 || op == 4'd6) begin
                tick();
                bus.e_md_op = op;
                bus.e_rs = a;
                if (op == 4'd5) mh = a;
                else ml = a;
                tick();
                bus.e_md_op = 4'd0;
                @(negedge clk);
                chk($sformatf("rnd%0d.mt_hi", i), bus.hi, mh);
                chk($sformatf("rnd%0d.mt_lo", i), bus.lo, ml);
            end else if (op == 4'd7 || op == 4'd8) begin
                tick();
                bus.e_md_op = op;
                @(negedge clk);
                chk($sformatf("rnd%0d.mf", i), bus.e_md_rdata,
                    (op == 4'd7) ? mh : ml);
            end else begin
                tick();
                bus.e_md_op = 4'd0;
            end
        end
        tick();
        bus.e_md_op = 4'd0;

`ifdef MDU_CANCEL_EN
        // Cancel mid-DIV keeps HI/LO; cancel with start blocks the launch.
        tick();
        bus.e_md_op = 4'd3;
        bus.e_rs = 32'd100;
        bus.e_rt = 32'd7;
        tick();
        bus.e_md_op = 4'd0;
        tick();
        tick();
        bus.md_cancel = 1'b1;
        tick();
        bus.md_cancel = 1'b0;
        @(negedge clk);
        chk("cancel.busy", 32'(bus.busy), 32'd0);
        chk("cancel.hi", bus.hi, mh);
        chk("cancel.lo", bus.lo, ml);
        tick();
        bus.e_md_op = 4'd1;
        bus.md_cancel = 1'b1;
        @(negedge clk);
        chk("cancel_start.start", 32'(bus.start), 32'd0);
        tick();
        bus.e_md_op = 4'd0;
        bus.md_cancel = 1'b0;
        @(negedge clk);
        chk("cancel_start.busy", 32'(bus.busy), 32'd0);
`endif

        // Reset on the 3rd busy cycle of a DIV.
        tick();
        bus.e_md_op = 4'd3;
        bus.e_rs = 32'd100;
        bus.e_rt = 32'd7;
        tick();
        bus.e_md_op = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        bus.d_is_md = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid.busy", 32'(bus.busy), 32'd0);
        chk("rstmid.hi", bus.hi, 32'd0);
        chk("rstmid.lo", bus.lo, 32'd0);
        chk("rstmid.stall", 32'(bus.md_stall), 32'd0);
        repeat (12) @(negedge clk);
        chk("rstmid.nocommit", bus.lo, 32'd0);
        bus.d_is_md = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
